vector_uop_sequencer: RTL and testbench

Registered, multi-cycle successor to the combinational control decoder in the RV32V core. It accepts one 32-bit instruction through a valid/ready handshake and decodes scalar (X) and vector (V) opcodes. It issues the result as a stream of micro-op beats to the execute stage. Vector operations are split into ceil(vl/LANES) beats, each carrying an element index and lane mask. The block owns the architectural vector-length register, which is updated by V_config.

---
 rtl/vector_uop_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_vector_uop_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vector_uop_sequencer.sv
// vector_uop_sequencer
// Accepts one RV32V instruction at a time over a valid/ready handshake,
// decodes it, and issues it to execute as a stream of registered micro-op
// beats. Vector ops are split into ceil(vl/LANES) beats carrying an element
// index and lane mask; everything else issues a single beat. Owns the
// architectural vector length, updated by V_config on its beat handshake.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr   instruction handshake and word
//   vl_req                          requested vl, captured at V_config accept
//   uop_valid/uop_ready             micro-op beat handshake
//   alu_control, alu_mux_sel        ALU op and operand select
//   reg_write_X/V, data_write,
//   v_len_write, vlsu_write         write enables
//   mux1/mux2/demux_select          datapath selects
//   elem_idx, lane_mask, uop_last   beat position, lane enables, last flag
//   illegal                         opcode not recognised
//   vl                              current vector length
module vector_uop_sequencer #(
   parameter int LANES  = 4,
   parameter int MAX_VL = 16,
   parameter int VL_W   = $clog2(MAX_VL + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [31:0]      instr,
   input  logic [31:0]      vl_req,
   output logic             uop_valid,
   input  logic             uop_ready,
   output logic [3:0]       alu_control,
   output logic [2:0]       alu_mux_sel,
   output logic             reg_write_X,
   output logic             reg_write_V,
   output logic             data_write,
   output logic             v_len_write,
   output logic             vlsu_write,
   output logic             mux1_select,
   output logic             mux2_select,
   output logic             demux_select,
   output logic [VL_W-1:0]  elem_idx,
   output logic [LANES-1:0] lane_mask,
   output logic             uop_last,
   output logic             illegal,
   output logic [VL_W-1:0]  vl
);

   localparam logic [6:0] OP_X_R = 7'd51, OP_X_I_LOAD = 7'd3, OP_X_I = 7'd19,
                          OP_X_B = 7'd99, OP_X_S = 7'd35, OP_X_J = 7'd111,
                          OP_X_I_JUMP = 7'd103, OP_V_R = 7'd24, OP_V_I = 7'd39,
                          OP_V_S = 7'd67, OP_V_I_LOAD = 7'd44, OP_V_CONFIG = 7'd98;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_uop_valid, r_uop_last, r_illegal;
   logic [3:0]       r_alu;
   logic [2:0]       r_mux;
   logic             r_rx, r_rv, r_dw, r_vlw, r_vlsu, r_m1, r_m2, r_dm;
   logic [VL_W-1:0]  r_elem_idx, r_vl, r_vl_pend;
   logic [LANES-1:0] r_lane_mask;

   logic [3:0]       w_alu;
   logic [2:0]       w_mux;
   logic             w_rx, w_rv, w_dw, w_cfg, w_m1, w_m2, w_dm, w_vec, w_illegal;
   logic             w_accept, w_start, w_fire;
   logic [VL_W-1:0]  w_next_idx;
   logic             w_unused;

   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
      case (f3)
         3'b000:  return 4'b0010;
         3'b011:  return 4'b0011;
         3'b111:  return 4'b0000;
         3'b110:  return 4'b0001;
         3'b100:  return 4'b0111;
         3'b010:  return 4'b0100;
         3'b001:  return 4'b0101;
         default: return 4'b0110;
      endcase
   endfunction

   // Lane i is live when its element index lies below the vector length.
   function automatic logic [LANES-1:0] mask_f(input logic [VL_W-1:0] base,
                                               input logic [VL_W-1:0] len);
      logic [LANES-1:0] m;
      for (int i = 0; i < LANES; i++) m[i] = (int'(base) + i < int'(len));
      return m;
   endfunction

   function automatic logic [VL_W-1:0] clamp_vl(input logic [31:0] req);
      if (req > 32'(MAX_VL)) return VL_W'(MAX_VL);
      return req[VL_W-1:0];
   endfunction

   // Instruction fields outside opcode/funct3 carry no control meaning here.
   assign w_unused = ^{instr[31:15], instr[11:7]};

   always_comb begin
      w_alu = 4'b0000; w_mux = 3'd0;
      w_rx = 1'b0; w_rv = 1'b0; w_dw = 1'b0; w_cfg = 1'b0;
      w_m1 = 1'b0; w_m2 = 1'b0; w_dm = 1'b0; w_vec = 1'b0; w_illegal = 1'b0;
      case (instr[6:0])
         OP_X_R:      begin w_alu = alu_from_f3(instr[14:12]); w_rx = 1'b1; end
         OP_X_I_LOAD: begin w_alu = 4'b0010; w_mux = 3'd1; w_rx = 1'b1; w_m1 = 1'b1; end
         OP_X_I:      begin w_alu = alu_from_f3(instr[14:12]); w_mux = 3'd1; w_rx = 1'b1; end
         OP_X_B:      w_alu = 4'b0100;
         OP_X_S:      begin w_alu = 4'b0010; w_mux = 3'd1; w_dw = 1'b1; end
         OP_X_J, OP_X_I_JUMP: ;
         OP_V_R:      begin
            w_alu = alu_from_f3(instr[14:12]); w_mux = 3'd2;
            w_rv = 1'b1; w_dm = 1'b1; w_vec = 1'b1;
         end
         OP_V_I:      begin
            w_alu = alu_from_f3(instr[14:12]); w_mux = 3'd3;
            w_rv = 1'b1; w_m2 = 1'b1; w_dm = 1'b1; w_vec = 1'b1;
         end
         OP_V_S:      begin
            w_alu = 4'b0010; w_mux = 3'd7; w_dw = 1'b1; w_m2 = 1'b1; w_vec = 1'b1;
         end
         OP_V_I_LOAD: begin
            w_alu = 4'b0010; w_mux = 3'd7; w_rv = 1'b1;
            w_m1 = 1'b1; w_m2 = 1'b1; w_dm = 1'b1; w_vec = 1'b1;
         end
         OP_V_CONFIG: w_cfg = 1'b1;
         default:     w_illegal = 1'b1;
      endcase
   end

   assign w_accept   = (r_state == S_IDLE) && instr_valid;
   // A vector op with vl==0 is consumed without issuing any beat.
   assign w_start    = w_accept && !(w_vec && (r_vl == '0));
   assign w_fire     = r_uop_valid && uop_ready;
   assign w_next_idx = r_elem_idx + VL_W'(LANES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_fire && r_uop_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uop_valid <= 1'b0; r_uop_last <= 1'b0; r_illegal <= 1'b0;
         r_alu <= '0; r_mux <= '0;
         r_rx <= 1'b0; r_rv <= 1'b0; r_dw <= 1'b0; r_vlw <= 1'b0; r_vlsu <= 1'b0;
         r_m1 <= 1'b0; r_m2 <= 1'b0; r_dm <= 1'b0;
         r_elem_idx <= '0; r_lane_mask <= '0; r_vl_pend <= '0;
         r_vl <= VL_W'(MAX_VL);
      end else if (w_start) begin
         r_uop_valid <= 1'b1;
         r_alu <= w_alu; r_mux <= w_mux; r_illegal <= w_illegal;
         r_rx <= w_rx; r_rv <= w_rv; r_dw <= w_dw; r_vlw <= w_cfg; r_vlsu <= w_cfg;
         r_m1 <= w_m1; r_m2 <= w_m2; r_dm <= w_dm;
         r_elem_idx  <= '0;
         r_lane_mask <= w_vec ? mask_f('0, r_vl) : '1;
         r_uop_last  <= w_vec ? (int'(r_vl) <= LANES) : 1'b1;
         r_vl_pend   <= clamp_vl(vl_req);
      end else if (w_fire) begin
         if (r_uop_last) begin
            r_uop_valid <= 1'b0;
            if (r_vlw) r_vl <= r_vl_pend;
         end else begin
            // vl cannot change mid-burst, so the tail is derived from it directly.
            r_elem_idx  <= w_next_idx;
            r_lane_mask <= mask_f(w_next_idx, r_vl);
            r_uop_last  <= (int'(w_next_idx) + LANES >= int'(r_vl));
         end
      end
   end

   assign instr_ready  = (r_state == S_IDLE);
   assign uop_valid    = r_uop_valid;
   assign alu_control  = r_alu;
   assign alu_mux_sel  = r_mux;
   assign reg_write_X  = r_rx;
   assign reg_write_V  = r_rv;
   assign data_write   = r_dw;
   assign v_len_write  = r_vlw;
   assign vlsu_write   = r_vlsu;
   assign mux1_select  = r_m1;
   assign mux2_select  = r_m2;
   assign demux_select = r_dm;
   assign elem_idx     = r_elem_idx;
   assign lane_mask    = r_lane_mask;
   assign uop_last     = r_uop_last;
   assign illegal      = r_illegal;
   assign vl           = r_vl;

endmodule

// File: tb/tb_vector_uop_sequencer.sv
module tb_vector_uop_sequencer;
   localparam int LANES = 4, MAX_VL = 16, VL_W = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic instr_valid = 1'b0, uop_ready = 1'b0;
   logic [31:0] instr = '0, vl_req = '0;
   logic instr_ready, uop_valid, reg_write_X, reg_write_V, data_write, v_len_write;
   logic vlsu_write, mux1_select, mux2_select, demux_select, uop_last, illegal;
   logic [3:0] alu_control;
   logic [2:0] alu_mux_sel;
   logic [VL_W-1:0] elem_idx, vl;
   logic [LANES-1:0] lane_mask;

   int n_tests = 0, n_fail = 0;
   int model_vl = MAX_VL;

   vector_uop_sequencer #(.LANES(LANES), .MAX_VL(MAX_VL)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .vl_req(vl_req), .uop_valid(uop_valid), .uop_ready(uop_ready),
      .alu_control(alu_control), .alu_mux_sel(alu_mux_sel),
      .reg_write_X(reg_write_X), .reg_write_V(reg_write_V), .data_write(data_write),
      .v_len_write(v_len_write), .vlsu_write(vlsu_write), .mux1_select(mux1_select),
      .mux2_select(mux2_select), .demux_select(demux_select), .elem_idx(elem_idx),
      .lane_mask(lane_mask), .uop_last(uop_last), .illegal(illegal), .vl(vl));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_pack();
      return {6'b0, alu_control, alu_mux_sel, reg_write_X, reg_write_V, data_write,
              v_len_write, vlsu_write, mux1_select, mux2_select, demux_select,
              elem_idx, lane_mask, uop_last, illegal};
   endfunction

   // Reference decode: {alu, mux_sel, rX, rV, dw, vlw, vlsu, m1, m2, dm}.
   function automatic void ref_dec(input logic [31:0] ins, output logic [14:0] d,
                                   output bit vec, output bit ill, output bit cfg);
      logic [3:0] a, fa;
      logic [2:0] m;
      bit rx, rv, dw, m1, m2, dm;
      a = 4'b0000; m = 3'd0; rx = 0; rv = 0; dw = 0; m1 = 0; m2 = 0; dm = 0;
      vec = 0; ill = 0; cfg = 0;
      case (ins[14:12])
         3'd0: fa = 4'd2; 3'd3: fa = 4'd3; 3'd7: fa = 4'd0; 3'd6: fa = 4'd1;
         3'd4: fa = 4'd7; 3'd2: fa = 4'd4; 3'd1: fa = 4'd5; default: fa = 4'd6;
      endcase
      case (int'(ins[6:0]))
         51:  begin a = fa; rx = 1; end
         3:   begin a = 4'd2; m = 3'd1; rx = 1; m1 = 1; end
         19:  begin a = fa; m = 3'd1; rx = 1; end
         99:  a = 4'd4;
         35:  begin a = 4'd2; m = 3'd1; dw = 1; end
         111, 103: ;
         24:  begin a = fa; m = 3'd2; rv = 1; dm = 1; vec = 1; end
         39:  begin a = fa; m = 3'd3; rv = 1; m2 = 1; dm = 1; vec = 1; end
         67:  begin a = 4'd2; m = 3'd7; dw = 1; m2 = 1; vec = 1; end
         44:  begin a = 4'd2; m = 3'd7; rv = 1; m1 = 1; m2 = 1; dm = 1; vec = 1; end
         98:  cfg = 1;
         default: ill = 1;
      endcase
      d = {a, m, rx, rv, dw, cfg, cfg, m1, m2, dm};
   endfunction

   function automatic logic [31:0] mk(input int op, input int f3);
      logic [31:0] w;
      w = $urandom;
      w[6:0] = 7'(op);
      w[14:12] = 3'(f3);
      return w;
   endfunction

   // Issue one instruction and check every beat against the reference.
   task automatic run_instr(input logic [31:0] ins, input logic [31:0] req,
                            input int stall_beat, input int stall_len, input bit rnd);
      logic [14:0] d;
      bit vec, ill, cfg;
      int nb, st;
      logic [LANES-1:0] msk;
      logic [31:0] exp;
      ref_dec(ins, d, vec, ill, cfg);
      nb = vec ? (model_vl + LANES - 1) / LANES : 1;
      @(negedge clk);
      check("ready_idle", {31'b0, instr_ready}, 1);
      instr_valid = 1'b1; instr = ins; vl_req = req;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = $urandom; vl_req = $urandom;
      if (nb == 0) begin
         @(negedge clk);
         check("skip_valid", {31'b0, uop_valid}, 0);
         check("skip_ready", {31'b0, instr_ready}, 1);
         return;
      end
      for (int k = 0; k < nb; k++) begin
         for (int i = 0; i < LANES; i++) msk[i] = vec ? (k * LANES + i < model_vl) : 1'b1;
         exp = {6'b0, d, VL_W'(vec ? k * LANES : 0), msk, (k == nb - 1), ill};
         st = (k == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
         repeat (st) begin
            @(negedge clk);
            uop_ready = 1'b0;
            check("hold_fields", obs_pack(), exp);
            check("hold_valid", {31'b0, uop_valid}, 1);
            check("hold_ready", {31'b0, instr_ready}, 0);
         end
         @(negedge clk);
         check("beat_fields", obs_pack(), exp);
         check("beat_valid", {31'b0, uop_valid}, 1);
         check("beat_ready", {31'b0, instr_ready}, 0);
         check("beat_vl", 32'(vl), 32'(model_vl));
         uop_ready = 1'b1;
         @(posedge clk); #1;
         uop_ready = 1'b0;
      end
      if (cfg) model_vl = (req > MAX_VL) ? MAX_VL : int'(req);
      @(negedge clk);
      check("done_valid", {31'b0, uop_valid}, 0);
      check("done_vl", 32'(vl), 32'(model_vl));
   endtask

   int ops[12] = '{51, 3, 19, 99, 35, 111, 103, 24, 39, 67, 44, 98};

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_fields", obs_pack(), 0);
      check("rst_valid", {31'b0, uop_valid}, 0);
      check("rst_ready", {31'b0, instr_ready}, 1);
      check("rst_vl", 32'(vl), MAX_VL);
      rst_n = 1'b1;

      // X_R sub
      run_instr(mk(51, 3), 0, -1, 0, 0);
      // V_config 10 then V_R add: three beats, tail mask 0011
      run_instr(mk(98, 0), 10, -1, 0, 0);
      run_instr(mk(24, 0), 0, -1, 0, 0);
      // V_config 100 clamps to 16, then V_S with four beats
      run_instr(mk(98, 0), 100, -1, 0, 0);
      run_instr(mk(67, 2), 0, -1, 0, 0);
      // Backpressure on beat 1 of V_I_load
      run_instr(mk(44, 2), 0, 1, 3, 0);
      // vl == 0 suppresses a vector op entirely
      run_instr(mk(98, 0), 0, -1, 0, 0);
      run_instr(mk(24, 0), 0, -1, 0, 0);
      // Unknown opcode
      run_instr(mk(7'h7F, 0), 0, -1, 0, 0);

      // Random mix with random backpressure
      for (int n = 0; n < 60; n++) begin
         int op;
         op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : ops[$urandom_range(0, 11)];
         run_instr(mk(op, int'($urandom_range(0, 7))), $urandom_range(0, 20), -1, 0, 1);
      end

      // Reset mid-burst of a vector op
      run_instr(mk(98, 0), 7, -1, 0, 0);
      @(negedge clk);
      instr_valid = 1'b1; instr = mk(24, 0);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", {31'b0, uop_valid}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_fields", obs_pack(), 0);
      check("async_rst_valid", {31'b0, uop_valid}, 0);
      check("async_rst_ready", {31'b0, instr_ready}, 1);
      check("async_rst_vl", 32'(vl), MAX_VL);
      model_vl = MAX_VL;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'b0, instr_ready}, 1);
      run_instr(mk(24, 1), 0, -1, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
